// File: rtl/output_deskew.sv
// output_deskew: collects the two serial column result streams leaving the
// bottom edge of the 2x2 systolic array, rebuilds the 2x2 result matrix in
// row-major registers and hands it to the consumer over valid/ready.
// Optional build macro: OUTPUT_DESKEW_RELU_EN (ReLU applied at capture).
module output_deskew #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              col_valid1,
   input  logic [DATA_W-1:0] col_data1,
   input  logic              col_valid2,
   input  logic [DATA_W-1:0] col_data2,
   output logic [DATA_W-1:0] c11,
   output logic [DATA_W-1:0] c12,
   output logic [DATA_W-1:0] c21,
   output logic [DATA_W-1:0] c22,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              overflow,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t     r_state;
   logic [1:0] r_row_cnt1;
   logic [1:0] r_row_cnt2;

   logic       w_cap1;
   logic       w_cap2;
   logic       w_drop1;
   logic       w_drop2;
   logic [1:0] w_cnt1_nxt;
   logic [1:0] w_cnt2_nxt;
   logic       w_both_full;
   logic       w_xfer;

   // Value written into the matrix for one captured beat.
   function automatic logic [DATA_W-1:0] relu_fn(input logic signed [DATA_W-1:0] x);
`ifdef OUTPUT_DESKEW_RELU_EN
      return (x < 0) ? '0 : x;
`else
      return x;
`endif
   endfunction

   // A beat is taken whenever the frame is still open and its column has room;
   // counters are zero in IDLE, so IDLE and COLLECT share the same rule.
   assign w_cap1      = col_valid1 && (r_state != ST_DONE) && (r_row_cnt1 != 2'd2);
   assign w_cap2      = col_valid2 && (r_state != ST_DONE) && (r_row_cnt2 != 2'd2);
   assign w_drop1     = col_valid1 && !w_cap1;
   assign w_drop2     = col_valid2 && !w_cap2;
   assign w_cnt1_nxt  = r_row_cnt1 + {1'b0, w_cap1};
   assign w_cnt2_nxt  = r_row_cnt2 + {1'b0, w_cap2};
   assign w_both_full = (w_cnt1_nxt == 2'd2) && (w_cnt2_nxt == 2'd2);
   assign w_xfer      = (r_state == ST_DONE) && result_ready;

   // Frame FSM: captures beats, tracks rows per column, raises the sticky
   // overflow flag and drives the registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_row_cnt1   <= 2'd0;
         r_row_cnt2   <= 2'd0;
         c11          <= '0;
         c12          <= '0;
         c21          <= '0;
         c22          <= '0;
         result_valid <= 1'b0;
         overflow     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         if (w_cap1) begin
            if (r_row_cnt1 == 2'd0) c11 <= relu_fn(col_data1);
            else                    c21 <= relu_fn(col_data1);
         end
         if (w_cap2) begin
            if (r_row_cnt2 == 2'd0) c12 <= relu_fn(col_data2);
            else                    c22 <= relu_fn(col_data2);
         end
         r_row_cnt1 <= w_cnt1_nxt;
         r_row_cnt2 <= w_cnt2_nxt;
         if (w_drop1 || w_drop2) overflow <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_cap1 || w_cap2) begin
                  r_state <= ST_COLLECT;
                  busy    <= 1'b1;
               end
            end
            ST_COLLECT: begin
               if (w_both_full) begin
                  r_state      <= ST_DONE;
                  result_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (w_xfer) begin
                  r_state      <= ST_IDLE;
                  r_row_cnt1   <= 2'd0;
                  r_row_cnt2   <= 2'd0;
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               result_valid <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_deskew.sv
// tb_output_deskew: directed frames plus random traffic for output_deskew,
// checked every cycle against a beat-counting matrix model.
module tb_output_deskew;

   logic        clk;
   logic        reset;
   logic        col_valid1;
   logic [15:0] col_data1;
   logic        col_valid2;
   logic [15:0] col_data2;
   logic [15:0] c11, c12, c21, c22;
   logic        result_valid;
   logic        result_ready;
   logic        overflow;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   // model: matrix in row-major order, beats taken per column, frame complete flag
   logic [15:0] m_c [4];
   int          m_got [2];
   bit          m_done;
   bit          m_ovf;

   output_deskew #(.DATA_W(16)) dut (
      .clk(clk), .reset(reset),
      .col_valid1(col_valid1), .col_data1(col_data1),
      .col_valid2(col_valid2), .col_data2(col_data2),
      .c11(c11), .c12(c12), .c21(c21), .c22(c22),
      .result_valid(result_valid), .result_ready(result_ready),
      .overflow(overflow), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef OUTPUT_DESKEW_RELU_EN
      return x[15] ? 16'h0000 : x;
`else
      return x;
`endif
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit v1, input logic [15:0] d1,
                             input bit v2, input logic [15:0] d2, input bit rdy);
      bit          v [2];
      logic [15:0] d [2];
      v[0] = v1; v[1] = v2; d[0] = d1; d[1] = d2;
      if (r) begin
         for (int i = 0; i < 4; i++) m_c[i] = 16'h0000;
         m_got[0] = 0; m_got[1] = 0;
         m_done = 0; m_ovf = 0;
      end else if (m_done) begin
         if (v1 || v2) m_ovf = 1;
         if (rdy) begin
            m_done = 0;
            m_got[0] = 0; m_got[1] = 0;
         end
      end else begin
         for (int col = 0; col < 2; col++) begin
            if (v[col]) begin
               if (m_got[col] < 2) begin
                  m_c[m_got[col]*2 + col] = relu(d[col]);
                  m_got[col]++;
               end else begin
                  m_ovf = 1;
               end
            end
         end
         if (m_got[0] == 2 && m_got[1] == 2) m_done = 1;
      end
   endtask

   task automatic compare_all();
      chk("c11", c11, m_c[0]);
      chk("c12", c12, m_c[1]);
      chk("c21", c21, m_c[2]);
      chk("c22", c22, m_c[3]);
      chk("result_valid", {15'd0, result_valid}, {15'd0, m_done});
      chk("overflow", {15'd0, overflow}, {15'd0, m_ovf});
      chk("busy", {15'd0, busy}, {15'd0, (m_done || m_got[0] > 0 || m_got[1] > 0)});
   endtask

   // one clock cycle: drive inputs, let the edge happen, advance model, compare
   task automatic cyc(input bit r, input bit v1, input logic [15:0] d1,
                      input bit v2, input logic [15:0] d2, input bit rdy);
      reset = r; col_valid1 = v1; col_data1 = d1;
      col_valid2 = v2; col_data2 = d2; result_ready = rdy;
      @(posedge clk);
      model_step(r, v1, d1, v2, d2, rdy);
      #1;
      compare_all();
   endtask

   initial begin
      logic [15:0] rd1, rd2;
      bit          rr, rv1, rv2, rrdy;

      // reset state
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_valid", {15'd0, result_valid}, 16'd0);
      chk("rst_c22", c22, 16'h0000);

      // nominal skew
      cyc(0, 1, 16'h0013, 0, 16'h0000, 1);
      cyc(0, 1, 16'h002B, 1, 16'h0016, 1);
      cyc(0, 0, 16'h0000, 1, 16'h0032, 1);
      chk("nom_valid", {15'd0, result_valid}, 16'd1);
      chk("nom_c11", c11, 16'h0013);
      chk("nom_c12", c12, 16'h0016);
      chk("nom_c21", c21, 16'h002B);
      chk("nom_c22", c22, 16'h0032);
      cyc(0, 0, 0, 0, 0, 1);
      chk("nom_valid_low", {15'd0, result_valid}, 16'd0);

      // backpressure
      cyc(0, 1, 16'h0013, 0, 16'h0000, 0);
      cyc(0, 1, 16'h002B, 1, 16'h0016, 0);
      cyc(0, 0, 16'h0000, 1, 16'h0032, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
      chk("bp_valid_held", {15'd0, result_valid}, 16'd1);
      chk("bp_c22_held", c22, 16'h0032);
      cyc(0, 0, 0, 0, 0, 1);
      chk("bp_busy_after", {15'd0, busy}, 16'd0);
      chk("bp_c11_kept", c11, 16'h0013);

      // reversed order: column 2 two cycles ahead
      cyc(0, 0, 0, 1, 16'h0016, 1);
      cyc(0, 0, 0, 1, 16'h0032, 1);
      cyc(0, 1, 16'h0013, 0, 0, 1);
      cyc(0, 1, 16'h002B, 0, 0, 1);
      chk("rev_valid", {15'd0, result_valid}, 16'd1);
      chk("rev_c21", c21, 16'h002B);
      chk("rev_ovf", {15'd0, overflow}, 16'd0);
      cyc(0, 0, 0, 0, 0, 1);

      // overflow: third col1 beat while col2 incomplete
      cyc(0, 1, 16'h0013, 1, 16'h0016, 1);
      cyc(0, 1, 16'h002B, 0, 0, 1);
      cyc(0, 1, 16'h7777, 0, 0, 1);
      chk("ovf_set", {15'd0, overflow}, 16'd1);
      chk("ovf_c21_kept", c21, 16'h002B);
      cyc(0, 0, 0, 1, 16'h0032, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("ovf_sticky", {15'd0, overflow}, 16'd1);

      // reset mid-frame
      cyc(0, 1, 16'h0005, 1, 16'h0006, 1);
      cyc(0, 1, 16'h0007, 0, 0, 1);
      cyc(1, 1, 16'h0009, 1, 16'h0009, 1);
      chk("mrst_c11", c11, 16'h0000);
      chk("mrst_ovf", {15'd0, overflow}, 16'd0);
      chk("mrst_busy", {15'd0, busy}, 16'd0);
      cyc(0, 1, 16'h0013, 0, 0, 1);
      cyc(0, 1, 16'h002B, 1, 16'h0016, 1);
      cyc(0, 0, 0, 1, 16'h0032, 1);
      chk("fresh_c12", c12, 16'h0016);
      cyc(0, 0, 0, 0, 0, 1);

      // negative c21 beat
      cyc(0, 1, 16'h0013, 0, 0, 1);
      cyc(0, 1, 16'hFFF0, 1, 16'h0016, 1);
      cyc(0, 0, 0, 1, 16'h0032, 1);
`ifdef OUTPUT_DESKEW_RELU_EN
      chk("relu_c21", c21, 16'h0000);
`else
      chk("relu_c21", c21, 16'hFFF0);
`endif
      chk("relu_c11", c11, 16'h0013);
      cyc(0, 0, 0, 0, 0, 1);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         rr   = ($urandom_range(0, 79) == 0);
         rv1  = ($urandom_range(0, 2) == 0);
         rv2  = ($urandom_range(0, 2) == 0);
         rrdy = ($urandom_range(0, 1) == 0);
         rd1  = 16'($urandom);
         rd2  = 16'($urandom);
         cyc(rr, rv1, rd1, rv2, rd2, rrdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
